mouse_bounds_ctl: RTL and testbench

- Parametrised successor to the fixed mouse constrainer; runs in the pixel-clock domain beside the mouse controller.
- Programs the mouse controller's bound and position registers through its setmax_x/setmax_y/setx/sety/value interface.
- Accepts runtime re-configuration and re-centre requests.
- Provides a registered, bound-clamped copy of the mouse position for the display path.

---
 rtl/mouse_bounds_ctl.sv | 167 ++++++++++++++++
 tb/tb_mouse_bounds_ctl.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_bounds_ctl.sv
// Mouse bound/position programmer with runtime re-configuration,
// re-centre requests and a registered clamp of the live cursor position.
module mouse_bounds_ctl #(
    parameter int W          = 12,
    parameter int MAX_X      = 1023,
    parameter int MAX_Y      = 767,
    parameter int STROBE_LEN = 4,
    parameter int GAP_LEN    = 2
) (
    input  logic         pclk,
    input  logic         rst,
    input  logic         cfg_req,
    input  logic [W-1:0] cfg_max_x,
    input  logic [W-1:0] cfg_max_y,
    input  logic         recenter_req,
    input  logic [W-1:0] xpos_in,
    input  logic [W-1:0] ypos_in,
    output logic         setmax_x,
    output logic         setmax_y,
    output logic         setx,
    output logic         sety,
    output logic [W-1:0] value,
    output logic         busy,
    output logic         cfg_done,
    output logic         cfg_err,
    output logic [W-1:0] xpos_out,
    output logic [W-1:0] ypos_out
);

    typedef enum logic [2:0] {
        IDLE,
        WMAXX,
        WMAXY,
        WPOSX,
        WPOSY,
        DONE
    } state_t;

    localparam int SEQ = STROBE_LEN + GAP_LEN;
    localparam int PW  = (SEQ > 2) ? $clog2(SEQ) : 1;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] phase;
    logic          run;
    logic          pend_cfg;
    logic          pend_ctr;
    logic [W-1:0]  act_max_x;
    logic [W-1:0]  act_max_y;
    logic [W-1:0]  shd_x;
    logic [W-1:0]  shd_y;
    logic [W-1:0]  value_nxt;
    logic          phase_last;
    logic          strobe_on;
    logic          cfg_ok;
    logic          enter_maxx;
    logic          enter_posx;

    assign phase_last = (phase == PW'(SEQ - 1));
    assign strobe_on  = (phase < PW'(STROBE_LEN));
    assign cfg_ok     = cfg_req && (cfg_max_x != '0) && (cfg_max_y != '0);

    // value is loaded on state entry; WMAXX shows the bounds committed that edge
    always_comb begin
        state_nxt = state;
        value_nxt = value;
        unique case (state)
            IDLE: begin
                if (run && pend_cfg) begin
                    state_nxt = WMAXX;
                    value_nxt = shd_x;
                end else if (run && pend_ctr) begin
                    state_nxt = WPOSX;
                    value_nxt = act_max_x >> 1;
                end
            end
            WMAXX: begin
                if (phase_last) begin
                    state_nxt = WMAXY;
                    value_nxt = act_max_y;
                end
            end
            WMAXY: begin
                if (phase_last) begin
                    state_nxt = WPOSX;
                    value_nxt = act_max_x >> 1;
                end
            end
            WPOSX: begin
                if (phase_last) begin
                    state_nxt = WPOSY;
                    value_nxt = act_max_y >> 1;
                end
            end
            WPOSY: begin
                if (phase_last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_maxx = (state == IDLE) && (state_nxt == WMAXX);
    assign enter_posx = (state == IDLE) && (state_nxt == WPOSX);

    // run holds the FSM in IDLE for one full cycle after reset release
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            phase <= '0;
            run   <= 1'b0;
            value <= '0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
            value <= value_nxt;
            if (state_nxt != state || state == IDLE) phase <= '0;
            else                                     phase <= phase + PW'(1);
        end
    end

    // A request arriving on the same edge as a commit wins over the clear
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            act_max_x <= W'(MAX_X);
            act_max_y <= W'(MAX_Y);
            shd_x     <= W'(MAX_X);
            shd_y     <= W'(MAX_Y);
            pend_cfg  <= 1'b1;
            pend_ctr  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= cfg_req && !cfg_ok;
            if (enter_maxx) begin
                act_max_x <= shd_x;
                act_max_y <= shd_y;
            end
            if (cfg_ok) begin
                shd_x    <= cfg_max_x;
                shd_y    <= cfg_max_y;
                pend_cfg <= 1'b1;
            end else if (enter_maxx) begin
                pend_cfg <= 1'b0;
            end
            if (recenter_req)                  pend_ctr <= 1'b1;
            else if (enter_maxx || enter_posx) pend_ctr <= 1'b0;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            xpos_out <= '0;
            ypos_out <= '0;
        end else begin
            xpos_out <= (xpos_in > act_max_x) ? act_max_x : xpos_in;
            ypos_out <= (ypos_in > act_max_y) ? act_max_y : ypos_in;
        end
    end

    assign setmax_x = (state == WMAXX) && strobe_on;
    assign setmax_y = (state == WMAXY) && strobe_on;
    assign setx     = (state == WPOSX) && strobe_on;
    assign sety     = (state == WPOSY) && strobe_on;
    assign busy     = (state != IDLE);
    assign cfg_done = (state == DONE);

endmodule

// File: tb/tb_mouse_bounds_ctl.sv
// Directed bench for mouse_bounds_ctl: strobe order/values/timing,
// request handling and clamp path against hand-computed expectations.
module tb_mouse_bounds_ctl;

    logic        pclk = 1'b0;
    logic        rst;
    logic        cfg_req;
    logic [11:0] cfg_max_x;
    logic [11:0] cfg_max_y;
    logic        recenter_req;
    logic [11:0] xpos_in;
    logic [11:0] ypos_in;
    logic        setmax_x;
    logic        setmax_y;
    logic        setx;
    logic        sety;
    logic [11:0] value;
    logic        busy;
    logic        cfg_done;
    logic        cfg_err;
    logic [11:0] xpos_out;
    logic [11:0] ypos_out;

    int total = 0;
    int bad   = 0;

    logic [3:0]  strb_log [0:255];
    logic [11:0] val_log  [0:255];
    int ncyc;
    int done1;
    int done2;

    int p_id    [0:31];
    int p_val   [0:31];
    int p_start [0:31];
    int p_len   [0:31];
    int np;
    int nmulti;
    int nunstable;

    always #5 pclk = ~pclk;

    mouse_bounds_ctl dut (
        .pclk         (pclk),
        .rst          (rst),
        .cfg_req      (cfg_req),
        .cfg_max_x    (cfg_max_x),
        .cfg_max_y    (cfg_max_y),
        .recenter_req (recenter_req),
        .xpos_in      (xpos_in),
        .ypos_in      (ypos_in),
        .setmax_x     (setmax_x),
        .setmax_y     (setmax_y),
        .setx         (setx),
        .sety         (sety),
        .value        (value),
        .busy         (busy),
        .cfg_done     (cfg_done),
        .cfg_err      (cfg_err),
        .xpos_out     (xpos_out),
        .ypos_out     (ypos_out)
    );

    task automatic pulse_cfg(input int x, input int y);
        @(negedge pclk);
        cfg_req   = 1'b1;
        cfg_max_x = 12'(x);
        cfg_max_y = 12'(y);
        @(negedge pclk);
        cfg_req   = 1'b0;
    endtask

    task automatic pulse_ctr();
        @(negedge pclk);
        recenter_req = 1'b1;
        @(negedge pclk);
        recenter_req = 1'b0;
    endtask

    // Log strobes/value each cycle until ndone cfg_done pulses are seen
    task automatic capture(input int ndone, input int maxc);
        int seen;
        seen  = 0;
        ncyc  = 0;
        done1 = -1;
        done2 = -1;
        for (int i = 0; i < maxc; i++) begin
            @(posedge pclk);
            #1;
            strb_log[i] = {setmax_x, setmax_y, setx, sety};
            val_log[i]  = value;
            ncyc        = i + 1;
            if (cfg_done) begin
                seen++;
                if (seen == 1) done1 = i + 1;
                done2 = i + 1;
            end
            if (seen >= ndone) break;
        end
        total++;
        if (seen < ndone) begin
            bad++;
            $display("FAIL capture_timeout: got %0d done pulses, need %0d", seen, ndone);
        end
    endtask

    // Split the log into strobe pulses (id 8=setmax_x 4=setmax_y 2=setx 1=sety)
    task automatic parse();
        logic [3:0] prev;
        prev      = 4'd0;
        np        = 0;
        nmulti    = 0;
        nunstable = 0;
        for (int i = 0; i < ncyc; i++) begin
            if ($countones(strb_log[i]) > 1) nmulti++;
            if (strb_log[i] != 4'd0 && strb_log[i] != prev && np < 32) begin
                p_id[np]    = int'(strb_log[i]);
                p_val[np]   = int'(val_log[i]);
                p_start[np] = i;
                p_len[np]   = 1;
                np++;
            end else if (strb_log[i] != 4'd0 && np > 0) begin
                p_len[np-1]++;
                if (int'(val_log[i]) != p_val[np-1]) nunstable++;
            end
            prev = strb_log[i];
        end
    endtask

    task automatic test_reset();
        int eid[4];
        int ev[4];
        eid = '{8, 4, 2, 1};
        ev  = '{1023, 767, 511, 383};
        repeat (3) @(negedge pclk);
        total++;
        if ({setmax_x, setmax_y, setx, sety, busy, cfg_done, cfg_err} !== 7'd0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {setmax_x, setmax_y, setx, sety, busy, cfg_done, cfg_err});
        end
        total++;
        if (value !== 12'd0 || xpos_out !== 12'd0 || ypos_out !== 12'd0) begin
            bad++;
            $display("FAIL reset_data: value=%0d x=%0d y=%0d want 0 0 0", value, xpos_out, ypos_out);
        end
        rst = 1'b0;
        capture(1, 100);
        parse();
        total++;
        if (np != 4) begin
            bad++;
            $display("FAIL por_pulses: got %0d want 4", np);
        end
        for (int k = 0; k < 4 && k < np; k++) begin
            total++;
            if (p_id[k] != eid[k] || p_val[k] != ev[k] || p_len[k] != 4) begin
                bad++;
                $display("FAIL por_pulse%0d: id=%0d val=%0d len=%0d want id=%0d val=%0d len=4",
                         k, p_id[k], p_val[k], p_len[k], eid[k], ev[k]);
            end
            if (k > 0) begin
                total++;
                if (p_start[k] - p_start[k-1] != 6) begin
                    bad++;
                    $display("FAIL por_spacing%0d: got %0d want 6", k, p_start[k] - p_start[k-1]);
                end
            end
        end
        total++;
        if (done1 != 26) begin
            bad++;
            $display("FAIL por_latency: cfg_done at cycle %0d want 26", done1);
        end
        total++;
        if (nmulti != 0 || nunstable != 0) begin
            bad++;
            $display("FAIL por_exclusive: multi=%0d unstable=%0d want 0 0", nmulti, nunstable);
        end
        @(posedge pclk);
        #1;
        total++;
        if (busy !== 1'b0 || cfg_done !== 1'b0) begin
            bad++;
            $display("FAIL por_idle: busy=%b done=%b want 0 0", busy, cfg_done);
        end
    endtask

    task automatic test_reject();
        int act;
        pulse_cfg(0, 500);
        total++;
        if (cfg_err !== 1'b1) begin
            bad++;
            $display("FAIL reject_err_x: got %b want 1", cfg_err);
        end
        @(posedge pclk);
        #1;
        total++;
        if (cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL reject_err_width: got %b want 0", cfg_err);
        end
        pulse_cfg(300, 0);
        total++;
        if (cfg_err !== 1'b1) begin
            bad++;
            $display("FAIL reject_err_y: got %b want 1", cfg_err);
        end
        act = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge pclk);
            #1;
            if (busy || setmax_x || setmax_y || setx || sety) act++;
        end
        total++;
        if (act != 0) begin
            bad++;
            $display("FAIL reject_quiet: active cycles %0d want 0", act);
        end
        @(negedge pclk);
        xpos_in = 12'd2000;
        ypos_in = 12'd800;
        @(posedge pclk);
        #1;
        total++;
        if (xpos_out !== 12'd1023 || ypos_out !== 12'd767) begin
            bad++;
            $display("FAIL reject_clamp: x=%0d y=%0d want 1023 767", xpos_out, ypos_out);
        end
        @(negedge pclk);
        xpos_in = 12'd0;
        ypos_in = 12'd0;
    endtask

    task automatic test_recenter();
        int eid[6];
        int ev[6];
        eid = '{8, 4, 2, 1, 2, 1};
        ev  = '{1023, 767, 511, 383, 511, 383};
        pulse_ctr();
        capture(1, 100);
        parse();
        total++;
        if (np != 2 || p_id[0] != 2 || p_val[0] != 511 || p_id[1] != 1 || p_val[1] != 383) begin
            bad++;
            $display("FAIL ctr_idle: np=%0d id0=%0d v0=%0d id1=%0d v1=%0d want 2 2 511 1 383",
                     np, p_id[0], p_val[0], p_id[1], p_val[1]);
        end
        total++;
        if (done1 != 13) begin
            bad++;
            $display("FAIL ctr_latency: got %0d want 13", done1);
        end
        pulse_cfg(1023, 767);
        fork
            capture(2, 200);
            begin
                repeat (7) @(negedge pclk);
                pulse_ctr();
            end
        join
        parse();
        total++;
        if (np != 6) begin
            bad++;
            $display("FAIL ctr_busy_pulses: got %0d want 6", np);
        end
        for (int k = 0; k < 6 && k < np; k++) begin
            total++;
            if (p_id[k] != eid[k] || p_val[k] != ev[k] || p_len[k] != 4) begin
                bad++;
                $display("FAIL ctr_busy_pulse%0d: id=%0d val=%0d len=%0d want id=%0d val=%0d len=4",
                         k, p_id[k], p_val[k], p_len[k], eid[k], ev[k]);
            end
        end
        total++;
        if (done1 != 25 || done2 != 39) begin
            bad++;
            $display("FAIL ctr_busy_done: got %0d,%0d want 25,39", done1, done2);
        end
    endtask

    task automatic test_cfg();
        int ev[4];
        ev = '{799, 599, 399, 299};
        pulse_cfg(799, 599);
        capture(1, 100);
        parse();
        total++;
        if (np != 4) begin
            bad++;
            $display("FAIL cfg_pulses: got %0d want 4", np);
        end
        for (int k = 0; k < 4 && k < np; k++) begin
            total++;
            if (p_val[k] != ev[k] || p_len[k] != 4) begin
                bad++;
                $display("FAIL cfg_pulse%0d: val=%0d len=%0d want val=%0d len=4",
                         k, p_val[k], p_len[k], ev[k]);
            end
        end
        total++;
        if (done1 != 25) begin
            bad++;
            $display("FAIL cfg_latency: got %0d want 25", done1);
        end
        @(negedge pclk);
        xpos_in = 12'd900;
        ypos_in = 12'd100;
        @(posedge pclk);
        #1;
        total++;
        if (xpos_out !== 12'd799 || ypos_out !== 12'd100) begin
            bad++;
            $display("FAIL cfg_clamp: x=%0d y=%0d want 799 100", xpos_out, ypos_out);
        end
        @(negedge pclk);
        xpos_in = 12'd799;
        ypos_in = 12'd600;
        @(posedge pclk);
        #1;
        total++;
        if (xpos_out !== 12'd799 || ypos_out !== 12'd599) begin
            bad++;
            $display("FAIL cfg_clamp_edge: x=%0d y=%0d want 799 599", xpos_out, ypos_out);
        end
        @(negedge pclk);
        xpos_in = 12'd0;
        ypos_in = 12'd0;
    endtask

    task automatic test_back_to_back();
        int ev[8];
        int act;
        ev = '{1000, 700, 500, 350, 319, 239, 159, 119};
        pulse_cfg(1000, 700);
        fork
            capture(2, 200);
            begin
                @(negedge pclk);
                pulse_cfg(639, 479);
                repeat (9) @(negedge pclk);
                pulse_cfg(319, 239);
            end
        join
        parse();
        total++;
        if (np != 8) begin
            bad++;
            $display("FAIL b2b_pulses: got %0d want 8", np);
        end
        for (int k = 0; k < 8 && k < np; k++) begin
            total++;
            if (p_val[k] != ev[k] || p_len[k] != 4) begin
                bad++;
                $display("FAIL b2b_pulse%0d: val=%0d len=%0d want val=%0d len=4",
                         k, p_val[k], p_len[k], ev[k]);
            end
        end
        total++;
        if (done2 != 51) begin
            bad++;
            $display("FAIL b2b_done: got %0d want 51", done2);
        end
        act = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge pclk);
            #1;
            if (busy) act++;
        end
        total++;
        if (act != 0) begin
            bad++;
            $display("FAIL b2b_no_third: busy cycles %0d want 0", act);
        end
    endtask

    task automatic test_reset_mid();
        int found;
        int ev[4];
        ev = '{1023, 767, 511, 383};
        pulse_cfg(1023, 767);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge pclk);
            #1;
            if (setmax_y) begin
                found = 1;
                break;
            end
        end
        total++;
        if (found != 1) begin
            bad++;
            $display("FAIL mid_wait_maxy: setmax_y seen=%0d want 1", found);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({setmax_x, setmax_y, setx, sety, busy} !== 5'd0 || value !== 12'd0) begin
            bad++;
            $display("FAIL mid_async: strobes/busy=%b value=%0d want 00000 0",
                     {setmax_x, setmax_y, setx, sety, busy}, value);
        end
        repeat (2) @(negedge pclk);
        rst = 1'b0;
        capture(1, 100);
        parse();
        total++;
        if (np != 4 || done1 != 26) begin
            bad++;
            $display("FAIL mid_rerun: pulses=%0d done=%0d want 4 26", np, done1);
        end
        for (int k = 0; k < 4 && k < np; k++) begin
            total++;
            if (p_val[k] != ev[k] || p_len[k] != 4) begin
                bad++;
                $display("FAIL mid_pulse%0d: val=%0d len=%0d want val=%0d len=4",
                         k, p_val[k], p_len[k], ev[k]);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        cfg_req      = 1'b0;
        cfg_max_x    = 12'd0;
        cfg_max_y    = 12'd0;
        recenter_req = 1'b0;
        xpos_in      = 12'd0;
        ypos_in      = 12'd0;
        test_reset();
        test_reject();
        test_recenter();
        test_cfg();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
